// File: rtl/logic_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op encodings,
// the flag bundle that travels with every result, and the per-bit gate.
package logic_pkg;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_NOT     = 3'd2;
  localparam logic [2:0] OP_NAND    = 3'd3;
  localparam logic [2:0] OP_NOR     = 3'd4;
  localparam logic [2:0] OP_XOR     = 3'd5;
  localparam logic [2:0] OP_XNOR    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  localparam int FLAG_W = 3;

  // Flags that accompany a result. The WIDTH-bit y field is packed in
  // front of this struct by the unit, since a package typedef cannot
  // follow a module parameter.
  typedef struct packed {
    logic zero;
    logic parity;
    logic op_err;
  } flags_t;

  // Single-bit gate; the unit applies it to every bit position so that
  // WIDTH=1 is exactly the original single-bit gate set.
  function automatic logic logic_eval(input logic [2:0] op,
                                      input logic a,
                                      input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_skid_buf.sv
// Generic two-entry valid/ready skid buffer. OUT drives the consumer
// directly; SKID absorbs the one beat that can arrive while OUT stalls,
// which lets in_ready come straight from a flop.
//
// Handshake: a beat moves when valid && ready are both high at a rising
// edge; a producer holding valid must keep its data stable until ready.
module logic_skid_buf #(
  parameter int             P_W      = 8,
  parameter logic [P_W-1:0] RST_DATA = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [P_W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] out_data
);

  logic           skid_valid;
  logic [P_W-1:0] skid_data;

  logic           out_valid_d;
  logic [P_W-1:0] out_data_d;
  logic           skid_valid_d;
  logic [P_W-1:0] skid_data_d;
  logic           accept;
  logic           deliver;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  // Next-state of both entries. in_ready is low whenever SKID is full, so
  // the SKID-drain branch never has to merge a new beat.
  always_comb begin
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    skid_valid_d = skid_valid;
    skid_data_d  = skid_data;
    if (skid_valid) begin
      if (deliver) begin
        out_data_d   = skid_data;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid || out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else if (deliver) begin
      // Data is left as-is so y and flags hold their last value.
      out_valid_d = 1'b0;
    end
  end

  // Entry registers and the registered ready, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= RST_DATA;
      skid_valid <= 1'b0;
      skid_data  <= RST_DATA;
      in_ready   <= 1'b1;
    end else begin
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      skid_valid <= skid_valid_d;
      skid_data  <= skid_data_d;
      in_ready   <= !skid_valid_d;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit: evaluates one of seven functions on two
// operands at accept, carries zero/parity/op_err alongside the result
// through a skid buffer, and counts accepted transactions.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic             op_err,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int P_W = WIDTH + FLAG_W;
  // Reset payload: y=0 with zero=1, parity=0, op_err=0.
  localparam logic [P_W-1:0] RST_DATA = {{WIDTH{1'b0}}, 3'b100};

  logic [WIDTH-1:0] res_y;
  flags_t           res_flags;
  logic [P_W-1:0]   out_payload;
  flags_t           out_flags;

  // Result and flags from the current operands; flags derive from the very
  // y they travel with, so op 7 naturally yields zero=1, parity=0.
  always_comb begin
    res_y = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res_y[i] = logic_eval(op, a[i], b[i]);
    end
    res_flags.zero   = ~|res_y;
    res_flags.parity = ^res_y;
    res_flags.op_err = (op == OP_ILLEGAL);
  end

  logic_skid_buf #(
    .P_W      (P_W),
    .RST_DATA (RST_DATA)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({res_y, res_flags}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign y         = out_payload[P_W-1:FLAG_W];
  assign out_flags = out_payload[FLAG_W-1:0];
  assign zero      = out_flags.zero;
  assign parity    = out_flags.parity;
  assign op_err    = out_flags.op_err;

  // Accepted-transaction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
    end else if (in_valid && in_ready) begin
      txn_cnt <= txn_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: an 8-bit instance checked through a
// scoreboard queue by a monitor, plus a WIDTH=1 / CNT_W=2 instance for
// single-bit gate behaviour and counter wrap.
module tb_logic_unit_pipe;
  import logic_pkg::*;

  localparam int W  = 8;
  localparam int PW = W + 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b, y;
  logic         zero, parity, op_err;
  logic [7:0]   txn_cnt;

  logic         in_valid1, in_ready1, out_valid1;
  logic [2:0]   op1;
  logic [0:0]   a1, b1, y1;
  logic         zero1, parity1, op_err1;
  logic [1:0]   txn_cnt1;

  logic_unit_pipe #(.WIDTH(W), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .parity(parity), .op_err(op_err), .txn_cnt(txn_cnt)
  );

  logic_unit_pipe #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .op(op1), .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(1'b1),
    .y(y1), .zero(zero1), .parity(parity1), .op_err(op_err1),
    .txn_cnt(txn_cnt1)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] exp_q[$];
  int            exp_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [PW-1:0] prev_val = '0;

  function automatic logic [PW-1:0] pk(input logic [W-1:0] yy, input logic z,
                                       input logic p, input logic e);
    return {yy, z, p, e};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one beat and holds it until in_ready is seen high at a
  // falling edge, pushing the hand-computed expectation at that point.
  task automatic send(input logic [2:0] o, input logic [W-1:0] aa,
                      input logic [W-1:0] bb, input logic [PW-1:0] e);
    bit done = 1'b0;
    in_valid = 1'b1; op = o; a = aa; b = bb;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        exp_cnt++;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=stuck required=accept at %0t", $time);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid)
        check("stable", {y, zero, parity, op_err}, prev_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out actual=%0h required=none at %0t",
                   {y, zero, parity, op_err}, $time);
        end else begin
          check("result", {y, zero, parity, op_err}, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_val   = {y, zero, parity, op_err};
    end
  end

  // ---------------- stimulus tables ----------------
  logic [2:0]    sw_op[7] = '{OP_AND, OP_OR, OP_NOT, OP_NAND, OP_NOR, OP_XOR, OP_XNOR};
  logic [W-1:0]  sw_y[7]  = '{8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, 8'hC3};

  logic [2:0]    mx_op[7] = '{OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_NOT, OP_XOR, OP_OR};
  logic [W-1:0]  mx_a[7]  = '{8'h01, 8'hFF, 8'h00, 8'h13, 8'hFE, 8'h07, 8'h80};
  logic [W-1:0]  mx_b[7]  = '{8'h00, 8'hFF, 8'h00, 8'h02, 8'h55, 8'h00, 8'h00};
  logic [PW-1:0] mx_e[7]  = '{{8'h01, 3'b010}, {8'h00, 3'b100}, {8'hFF, 3'b000},
                              {8'hEE, 3'b000}, {8'h01, 3'b010}, {8'h07, 3'b010},
                              {8'h80, 3'b010}};

  logic [2:0]    s1_op[5] = '{OP_AND, OP_NAND, OP_XOR, OP_XNOR, OP_NOT};
  logic          s1_a[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic          s1_b[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic          s1_y[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0]    s1_c[5]  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;

    // Reset values.
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_y", y, 0);
    check("rst_flags", {zero, parity, op_err}, 3'b100);
    check("rst_txn_cnt", txn_cnt, 0);
    check("rst1_state", {out_valid1, in_ready1, y1, zero1, txn_cnt1}, 6'b010100);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Truth-table sweep, back-to-back, one cycle latency each.
    for (int i = 0; i < 7; i++) begin
      send(sw_op[i], 8'hF0, 8'hCC, pk(sw_y[i], sw_y[i] == 0, ^sw_y[i], 1'b0));
      check("sweep_valid", out_valid, 1);
      check("sweep_y", y, sw_y[i]);
    end

    // Mixed vectors covering zero and parity flags.
    for (int i = 0; i < 7; i++) send(mx_op[i], mx_a[i], mx_b[i], mx_e[i]);
    repeat (3) @(posedge clk); #1;
    check("txn_cnt_mid", txn_cnt, exp_cnt);

    // Backpressure: OUT then SKID fill, third beat held.
    out_ready = 1'b0;
    send(OP_XOR, 8'hA5, 8'h5A, pk(8'hFF, 1'b0, 1'b0, 1'b0));
    send(OP_AND, 8'hA5, 8'h0F, pk(8'h05, 1'b0, 1'b0, 1'b0));
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_y_first", y, 8'hFF);
    fork
      send(OP_OR, 8'hA5, 8'h0F, pk(8'hAF, 1'b0, 1'b0, 1'b0));
      begin
        repeat (4) @(posedge clk); #2;
        check("bp_held", in_ready, 0);
        check("bp_y_hold", y, 8'hFF);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    check("bp_drain", exp_q.size(), 0);
    check("bp_txn_cnt", txn_cnt, exp_cnt);
    check("bp_out_idle", out_valid, 0);
    check("bp_y_hold_idle", y, 8'hAF);

    // Illegal op then a legal op clears op_err.
    send(OP_ILLEGAL, 8'hFF, 8'h00, pk(8'h00, 1'b1, 1'b0, 1'b1));
    check("ill_err", op_err, 1);
    send(OP_AND, 8'hFF, 8'h0F, pk(8'h0F, 1'b0, 1'b0, 1'b0));
    check("ill_clear", op_err, 0);
    repeat (3) @(posedge clk); #1;

    // Single-bit instance: gate behaviour and 2-bit counter wrap.
    for (int i = 0; i < 5; i++) begin
      in_valid1 = 1'b1; op1 = s1_op[i]; a1 = s1_a[i]; b1 = s1_b[i];
      @(posedge clk); #1;
      check("w1_y", y1, s1_y[i]);
      check("w1_cnt", txn_cnt1, s1_c[i]);
    end
    in_valid1 = 1'b0;

    // Mid-stream reset with both entries full.
    out_ready = 1'b0;
    send(OP_OR, 8'h11, 8'h22, pk(8'h33, 1'b0, 1'b0, 1'b0));
    send(OP_OR, 8'h44, 8'h00, pk(8'h44, 1'b0, 1'b0, 1'b0));
    check("mr_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mr_out_valid", out_valid, 0);
    check("mr_in_ready", in_ready, 1);
    check("mr_y_flags", {y, zero, parity, op_err}, pk(8'h00, 1'b1, 1'b0, 1'b0));
    check("mr_txn_cnt", txn_cnt, 0);
    exp_q.delete();
    exp_cnt = 0;
    out_ready = 1'b1;
    @(negedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mr_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    send(OP_XNOR, 8'h0F, 8'h0F, pk(8'hFF, 1'b0, 1'b0, 1'b0));
    check("mr_first_y", y, 8'hFF);
    repeat (3) @(posedge clk); #1;
    check("final_drain", exp_q.size(), 0);
    check("final_txn_cnt", txn_cnt, exp_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
